// File: rtl/biquad_pkg.sv
// Shared widths and state encoding for the biquad datapath divider.
package biquad_pkg;

  localparam int unsigned DATAWIDTH_DEF = 16;
  localparam int unsigned COEFWIDTH_DEF = 16;

  function automatic int unsigned calc_qw(input int unsigned data_w);
    return data_w + 3;
  endfunction

  function automatic int unsigned calc_dw(input int unsigned coef_w);
    return coef_w - 1;
  endfunction

  function automatic int unsigned calc_pw(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w + 2;
  endfunction

  localparam int unsigned QW = calc_qw(DATAWIDTH_DEF);
  localparam int unsigned DW = calc_dw(COEFWIDTH_DEF);
  localparam int unsigned PW = calc_pw(DATAWIDTH_DEF, COEFWIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/diva_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module diva_step #(
  parameter int unsigned DW = 15
) (
  input  logic [DW-1:0] r_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] r_o,
  output logic          q_o
);

  logic [DW:0] t;
  logic [DW:0] diff;

  assign t    = {r_i, bit_i};
  assign diff = t - {1'b0, divisor_i};

  // R < divisor on entry, so both T and T-divisor results fit back into DW bits.
  always_comb begin
    q_o = (t >= {1'b0, divisor_i});
    r_o = q_o ? diff[DW-1:0] : t[DW-1:0];
  end

endmodule

// File: rtl/diva.sv
// Sequential unsigned divider (one quotient bit per clock), inverse of the multa multiplier.
module diva
  import biquad_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned COEFWIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [calc_pw(DATAWIDTH, COEFWIDTH)-1:0] dividend,
  input  logic [calc_dw(COEFWIDTH)-1:0]         divisor,
  output logic                                  busy,
  output logic                                  done,
  output logic [calc_qw(DATAWIDTH)-1:0]         quotient,
  output logic [calc_dw(COEFWIDTH)-1:0]         remainder,
  output logic                                  overflow,
  output logic                                  div_by_zero
);

  localparam int unsigned L_QW  = calc_qw(DATAWIDTH);
  localparam int unsigned L_DW  = calc_dw(COEFWIDTH);
  localparam int unsigned L_PW  = calc_pw(DATAWIDTH, COEFWIDTH);
  localparam int unsigned CNT_W = $clog2(L_QW + 1);

  state_e            state_q, state_d;
  logic [L_DW-1:0]   r_q, r_d;
  logic [L_QW-1:0]   q_q, q_d;
  logic [L_DW-1:0]   divisor_q, divisor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [L_QW-1:0]   quotient_q, quotient_d;
  logic [L_DW-1:0]   remainder_q, remainder_d;
  logic              overflow_q, overflow_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [L_DW-1:0]   step_r;
  logic              step_bit;
  logic [L_DW-1:0]   dvd_hi;

  assign dvd_hi = dividend[L_PW-1:L_QW];

  diva_step #(.DW(L_DW)) u_step (
    .r_i       (r_q),
    .bit_i     (q_q[L_QW-1]),
    .divisor_i (divisor_q),
    .r_o       (step_r),
    .q_o       (step_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Results are loaded on the edge entering DONE so they are valid with the done pulse.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          divisor_d  = divisor;
          overflow_d = 1'b0;
          dbz_d      = 1'b0;
          if (divisor == '0) begin
            r_d         = '0;
            q_d         = '1;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else if (dvd_hi >= divisor) begin
            r_d         = '0;
            q_d         = '1;
            quotient_d  = '1;
            remainder_d = '0;
            overflow_d  = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            r_d     = dvd_hi;
            q_d     = dividend[L_QW-1:0];
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = {q_q[L_QW-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(L_QW - 1)) begin
          quotient_d  = {q_q[L_QW-2:0], step_bit};
          remainder_d = step_r;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_diva.sv
// Self-checking bench for diva: directed scenarios plus randomized operands against an arithmetic model.
module tb_diva;

  logic        clk;
  logic        reset;
  logic        start;
  logic [33:0] dividend;
  logic [14:0] divisor;
  logic        busy;
  logic        done;
  logic [18:0] quotient;
  logic [14:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  int n_checks;
  int n_fail;

  diva #(.DATAWIDTH(16), .COEFWIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division with the saturation rules for zero divisor and overflow.
  function automatic void model(input longint dvd, input longint dvs,
                                output longint q, output longint r,
                                output bit ovf, output bit dbz);
    ovf = 1'b0;
    dbz = 1'b0;
    if (dvs == 0) begin
      q = 524287; r = 0; dbz = 1'b1;
    end else if (dvd / dvs >= 524288) begin
      q = 524287; r = 0; ovf = 1'b1;
    end else begin
      q = dvd / dvs; r = dvd % dvs;
    end
  endfunction

  // Presents one start pulse; returns at the falling edge just after the sampling edge.
  task automatic start_op(input longint dvd, input longint dvs);
    @(negedge clk);
    start    = 1'b1;
    dividend = 34'(dvd);
    divisor  = 15'(dvs);
    @(negedge clk);
    start    = 1'b0;
    dividend = 34'($urandom);
    divisor  = 15'($urandom);
  endtask

  // Latency counts the sampling edge as 1; a timeout shows up as a latency of 100.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, overflow, div_by_zero} !== 4'b0 || quotient !== 19'd0 || remainder !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d ovf=%b dbz=%b, want all 0",
               busy, done, quotient, remainder, overflow, div_by_zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    start_op(1000, 7);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 20) begin n_fail++; $display("FAIL basic_latency: got %0d want 20", lat); end
    n_checks++;
    if (bc !== 19) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 19", bc); end
    n_checks++;
    if (quotient !== 19'd142 || remainder !== 15'd6) begin
      n_fail++; $display("FAIL basic_result: got q=%0d r=%0d want q=142 r=6", quotient, remainder);
    end
    n_checks++;
    if (overflow !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_flags: got ovf=%b dbz=%b busy=%b want 0 0 0", overflow, div_by_zero, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got done=%b want 0", done); end
  endtask

  task automatic test_roundtrip();
    int lat, bc;
    longint dvd;
    dvd = 64'h1234 * 64'h56789;
    start_op(dvd, 64'h1234);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 20 || quotient !== 19'h56789 || remainder !== 15'd0) begin
      n_fail++; $display("FAIL roundtrip: got lat=%0d q=%h r=%0d want lat=20 q=56789 r=0", lat, quotient, remainder);
    end
  endtask

  task automatic test_zero_div();
    int lat, bc;
    start_op(55, 0);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_div_timing: got lat=%0d busy=%b want lat=1 busy=0", lat, busy);
    end
    n_checks++;
    if (quotient !== 19'h7FFFF || remainder !== 15'd0 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL zero_div_result: got q=%h r=%0d dbz=%b ovf=%b want 7ffff 0 1 0",
                         quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    start_op(longint'(7) << 19, 7);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL overflow_timing: got lat=%0d busy=%b want lat=1 busy=0", lat, busy);
    end
    n_checks++;
    if (quotient !== 19'h7FFFF || remainder !== 15'd0 || overflow !== 1'b1 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL overflow_result: got q=%h r=%0d ovf=%b dbz=%b want 7ffff 0 1 0",
                         quotient, remainder, overflow, div_by_zero);
    end
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    start_op(1000, 7);
    repeat (4) begin
      @(negedge clk);
      start = 1'b1; dividend = 34'd100; divisor = 15'd0;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(lat, bc);
    n_checks++;
    if (quotient !== 19'd142 || remainder !== 15'd6 || div_by_zero !== 1'b0 || lat + 8 !== 20) begin
      n_fail++; $display("FAIL ignored_start: got q=%0d r=%0d dbz=%b lat=%0d want q=142 r=6 dbz=0 lat=12",
                         quotient, remainder, div_by_zero, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit saw_done;
    start_op(1000, 3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, overflow, div_by_zero} !== 4'b0 || quotient !== 19'd0 || remainder !== 15'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%0d r=%0d want all 0",
                         busy, done, quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_done: got done pulse, want none"); end
    start_op(1000, 7);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 20 || quotient !== 19'd142 || remainder !== 15'd6) begin
      n_fail++; $display("FAIL reset_mid_rerun: got lat=%0d q=%0d r=%0d want 20 142 6", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_op(1000, 7);
    wait_done(lat, bc);
    start = 1'b1; dividend = 34'd100; divisor = 15'd3;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || quotient !== 19'd142 || remainder !== 15'd6) begin
      n_fail++; $display("FAIL b2b_hold: got done=%b busy=%b q=%0d r=%0d want 0 1 142 6",
                         done, busy, quotient, remainder);
    end
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 20 || quotient !== 19'd33 || remainder !== 15'd1) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want 20 33 1", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc;
    longint dvd, dvs, hi, eq, er;
    bit eovf, edbz;
    for (int i = 0; i < 40; i++) begin
      dvs = ($urandom_range(0, 9) == 0) ? 0 : longint'($urandom_range(1, 32767));
      if (dvs != 0 && $urandom_range(0, 4) != 0) hi = longint'($urandom) % dvs;
      else hi = longint'($urandom_range(0, 32767));
      dvd = (hi << 19) | longint'($urandom_range(0, 524287));
      model(dvd, dvs, eq, er, eovf, edbz);
      start_op(dvd, dvs);
      wait_done(lat, bc);
      n_checks++;
      if (quotient !== 19'(eq) || remainder !== 15'(er) || overflow !== eovf || div_by_zero !== edbz ||
          lat !== ((eovf || edbz) ? 1 : 20)) begin
        n_fail++;
        $display("FAIL random_%0d: dvd=%0d dvs=%0d got q=%0d r=%0d ovf=%b dbz=%b lat=%0d want q=%0d r=%0d ovf=%b dbz=%b",
                 i, dvd, dvs, quotient, remainder, overflow, div_by_zero, lat, eq, er, eovf, edbz);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_roundtrip();
    test_zero_div();
    test_overflow();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
